// File: rtl/req_ack_pkg.sv
// Shared types for the request/acknowledge scheduler: FSM state encoding and counter width.
package req_ack_pkg;

    // 4 bits covers ACK_DELAY up to 15
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        ACK
    } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set candidate after `last`, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] cand,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int unsigned pos;

    // Walk from the farthest position back to the nearest so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            pos = (32'(last) + k) % NUM_REQ;
            if (cand[pos]) begin
                valid = 1'b1;
                index = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/req_ack_scheduler.sv
// Round-robin scheduler returning a one-cycle ack a fixed ACK_DELAY edges after each grant.
module req_ack_scheduler
    import req_ack_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ACK_DELAY = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       dropped
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    sched_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic               dropped_q, dropped_d;

    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] cand;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_index;
    logic               grant_now;

    assign rise = req & ~req_q;
    assign cand = pending_q | rise;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .cand  (cand),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_index)
    );

    // A new grant may only be issued when idle or on the edge that retires the previous ack.
    assign grant_now = pick_valid && ((state_q == IDLE) || (state_q == ACK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            req_q     <= '0;
            pending_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            req_q     <= req;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(ACK_DELAY - 2);
                end
            end
            COUNT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                if (pick_valid) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(ACK_DELAY - 2);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        last_d    = last_q;
        pending_d = cand;
        dropped_d = dropped_q | (|(pending_q & rise));
        if (grant_now) begin
            grant_d               = pick_index;
            last_d                = pick_index;
            pending_d[pick_index] = 1'b0;
        end
    end

    always_comb begin
        ack  = '0;
        busy = (state_q != IDLE);
        if (state_q == ACK) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign grant_id = grant_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_req_ack_scheduler.sv
// Self-checking bench: two schedulers (ACK_DELAY 3 and 2) against an edge-count reference model.
module tb_req_ack_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ack_a, ack_b;
    logic       busy_a, busy_b;
    logic [1:0] gid_a, gid_b;
    logic       drop_a, drop_b;

    always #5 clk = ~clk;

    req_ack_scheduler #(.NUM_REQ(4), .ACK_DELAY(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_a), .busy(busy_a),
        .grant_id(gid_a), .dropped(drop_a)
    );

    req_ack_scheduler #(.NUM_REQ(4), .ACK_DELAY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_b), .busy(busy_b),
        .grant_id(gid_b), .dropped(drop_b)
    );

    wire [7:0] obs_a = {ack_a, busy_a, gid_a, drop_a};
    wire [7:0] obs_b = {ack_b, busy_b, gid_b, drop_b};

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference model: a grant at edge G owns the responder until edge G+D, ack visible after G+D-1.
    int         m_dly[2];
    int         m_gedge[2];
    logic [3:0] m_pend[2];
    logic [3:0] m_reqq[2];
    logic [3:0] m_ack[2];
    logic [1:0] m_gid[2];
    logic [1:0] m_last[2];
    logic       m_drop[2];
    logic       m_busy[2];

    task automatic model_reset();
        m_dly[0] = 3;
        m_dly[1] = 2;
        for (int u = 0; u < 2; u++) begin
            m_gedge[u] = -1;
            m_pend[u]  = '0;
            m_reqq[u]  = '0;
            m_ack[u]   = '0;
            m_gid[u]   = '0;
            m_last[u]  = 2'd3;
            m_drop[u]  = 1'b0;
            m_busy[u]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int u, input logic [3:0] r);
        logic [3:0] rise;
        logic [3:0] cand;
        bit         free;
        bit         found;
        int         pick;
        int         p;
        rise = r & ~m_reqq[u];
        m_reqq[u] = r;
        cand = m_pend[u] | rise;
        if ((m_pend[u] & rise) != 4'b0) m_drop[u] = 1'b1;
        free = (m_gedge[u] < 0) || (edge_n == m_gedge[u] + m_dly[u]);
        m_pend[u] = cand;
        if (free) begin
            m_gedge[u] = -1;
            found = 1'b0;
            pick = 0;
            for (int k = 1; k <= N; k++) begin
                p = (int'(m_last[u]) + k) % N;
                if (!found && cand[p]) begin
                    found = 1'b1;
                    pick = p;
                end
            end
            if (found) begin
                m_gedge[u] = edge_n;
                m_gid[u] = 2'(pick);
                m_last[u] = 2'(pick);
                m_pend[u][pick] = 1'b0;
            end
        end
        m_busy[u] = (m_gedge[u] >= 0);
        m_ack[u] = (m_gedge[u] >= 0 && edge_n == m_gedge[u] + m_dly[u] - 1)
                   ? 4'(1 << m_gid[u]) : 4'b0;
    endtask

    function automatic logic [7:0] exp_vec(input int u);
        return {m_ack[u], m_busy[u], m_gid[u], m_drop[u]};
    endfunction

    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        edge_n++;
        model_edge(0, r);
        model_edge(1, r);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs_a !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_a: got %b want %b", obs_a, 8'h00);
        end
        n_cmp++;
        if (obs_b !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_b: got %b want %b", obs_b, 8'h00);
        end
    endtask

    task automatic test_single_pulse();
        int t;
        int na;
        na = 0;
        repeat (3) tick(4'b0000);
        tick(4'b0001);
        t = edge_n;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick(4'b0000);
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL single_a edge %0d: got %b want %b", edge_n, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL single_b edge %0d: got %b want %b", edge_n, obs_b, exp_vec(1));
            end
            if (ack_a !== 4'b0000) begin
                na++;
                n_cmp++;
                if (edge_n != t + 2 || ack_a !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL single_timing: ack %b after edge %0d, want 0001 after %0d",
                             ack_a, edge_n, t + 2);
                end
            end
        end
        n_cmp++;
        if (na != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d acks want 1", na);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(4'b0110);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick(4'b0000);
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL simul_a edge %0d: got %b want %b", edge_n, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL simul_b edge %0d: got %b want %b", edge_n, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] r;
        logic [3:0] r_next;
        int rise_e[4];
        int k;
        int idx;
        do_reset();
        k = 0;
        r = '0;
        r_next = 4'b1111;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!r[i] && r_next[i]) rise_e[i] = edge_n + 1;
            end
            r = r_next;
            tick(r);
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL rr_a edge %0d: got %b want %b", edge_n, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL rr_b edge %0d: got %b want %b", edge_n, obs_b, exp_vec(1));
            end
            if (ack_a !== 4'b0000) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (ack_a[i]) idx = i;
                n_cmp++;
                if (idx != k % 4 || edge_n + 1 - rise_e[idx] > 12) begin
                    n_bad++;
                    $display("FAIL rr_order: ack %b latency %0d, want index %0d within 12",
                             ack_a, edge_n + 1 - rise_e[idx], k % 4);
                end
                k++;
            end
            r_next = ~ack_a;
        end
        n_cmp++;
        if (k < 12) begin
            n_bad++;
            $display("FAIL rr_grants: got %0d grants want at least 12", k);
        end
    endtask

    task automatic test_drop();
        logic [3:0] seq[4];
        int n3;
        seq = '{4'b0001, 4'b1000, 4'b0000, 4'b1000};
        n3 = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            tick(c < 4 ? seq[c] : 4'b0000);
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL drop_a edge %0d: got %b want %b", edge_n, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL drop_b edge %0d: got %b want %b", edge_n, obs_b, exp_vec(1));
            end
            if (ack_a[3]) n3++;
        end
        n_cmp++;
        if (drop_a !== 1'b1 || n3 != 1) begin
            n_bad++;
            $display("FAIL drop_flag: dropped %b ack3 count %0d, want 1 and 1", drop_a, n3);
        end
    endtask

    task automatic test_reset_mid();
        int na;
        int t;
        na = 0;
        do_reset();
        tick(4'b0001);
        tick(4'b0001);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ack_a, busy_a, ack_b, busy_b} !== 10'b0) begin
            n_bad++;
            $display("FAIL midreset_async: got %b want %b", {ack_a, busy_a, ack_b, busy_b}, 10'b0);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({ack_a, busy_a, ack_b, busy_b} !== 10'b0) begin
                n_bad++;
                $display("FAIL midreset_hold: got %b want %b",
                         {ack_a, busy_a, ack_b, busy_b}, 10'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(4'b0001);
        t = edge_n;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick(4'b0001);
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL midreset_a edge %0d: got %b want %b", edge_n, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL midreset_b edge %0d: got %b want %b", edge_n, obs_b, exp_vec(1));
            end
            if (ack_a[0]) begin
                na++;
                n_cmp++;
                if (edge_n != t + 2) begin
                    n_bad++;
                    $display("FAIL midreset_timing: ack after edge %0d want %0d", edge_n, t + 2);
                end
            end
        end
        n_cmp++;
        if (na != 1) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d acks want 1", na);
        end
    endtask

    task automatic test_held_high();
        int na;
        int nb;
        na = 0;
        nb = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            tick(c < 10 ? 4'b0001 : 4'b0000);
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL held_a edge %0d: got %b want %b", edge_n, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL held_b edge %0d: got %b want %b", edge_n, obs_b, exp_vec(1));
            end
            if (ack_a !== 4'b0000) na++;
            if (ack_b !== 4'b0000) nb++;
        end
        n_cmp++;
        if (na != 1 || nb != 1) begin
            n_bad++;
            $display("FAIL held_count: got %0d/%0d acks want 1/1", na, nb);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            tick(r);
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL random_a edge %0d: got %b want %b", edge_n, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL random_b edge %0d: got %b want %b", edge_n, obs_b, exp_vec(1));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        model_reset();
        test_reset();
        test_single_pulse();
        test_simultaneous();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_held_high();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/req_ack_scheduler.md
# req_ack_scheduler

Schedules fixed-latency acknowledgements for several requesters that share a single request/acknowledge responder. Each requester raises `req`. The block detects the rising edge and queues the request. A round-robin policy grants one requester at a time, and the block returns a one-cycle `ack` exactly `ACK_DELAY` sampling edges after the grant. It sits between the requesters and the shared resource, and enforces the constant-delay req→ack contract checked by the team's delay-operator assertions.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `ACK_DELAY`, default 3: sampling edges from grant to `ack` sampled high, range 2..15.
- `clk` input 1: single clock, posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input NUM_REQ: per-requester request level; only the rising edge is significant.
- `ack` output NUM_REQ: one-hot, one-cycle acknowledge pulse.
- `busy` output 1: a grant is outstanding.
- `grant_id` output $clog2(NUM_REQ): index of the current or last grant.
- `dropped` output 1: sticky flag; a rising edge arrived while that requester was already pending.

## Operation
- Edge detect:
  - `rise[i] = req[i] & ~req_q[i]`.
  - `req_q` is registered every edge.
  - A `rise[i]` at edge E sets `pending[i]` at E, unless requester i is granted at the same edge E.
- If `pending[i]` is already 1 when `rise[i]` occurs, the request is absorbed and `dropped` sets to 1. It stays 1 until reset.
- A rise for the requester currently in COUNT/ACK is not a drop; it sets `pending` for a later grant.
- Candidates at a grant edge are `pending | rise`.
- Round-robin pick:
  - Search starts at the last granted index + 1, wrapping modulo NUM_REQ.
  - After reset the search starts at index 0.
- FSM states IDLE, COUNT, ACK:
  - IDLE: if any candidate, grant it at this edge (edge G). Load `cnt = ACK_DELAY-2`, set `grant_id`, go to COUNT. Clear `pending[grant]`.
  - COUNT: decrement `cnt`. When `cnt==0`, go to ACK and drive `ack[grant_id]=1`.
  - ACK: drive `ack` to 0. If any candidate, grant at this edge and go to COUNT; otherwise go to IDLE.
- `busy = (state != IDLE)`, registered with the state.
- Reset values: `ack=0`, `busy=0`, `grant_id=0`, `dropped=0`, `pending=0`, `req_q=0`, state IDLE, RR pointer so that index 0 has top priority.
- Reset mid-operation:
  - All state clears immediately, asynchronously, and no `ack` is issued for an in-flight grant.
  - A `req` held high through reset release is seen as a rise at the first edge after release.

## Timing
- Grant at edge G means `ack[grant_id]` samples 1 at edge G+ACK_DELAY and 0 at edge G+ACK_DELAY+1.
- Uncontended request when IDLE: `$rose(req[i])` at edge T gives `ack[i]` sampled rising at T+ACK_DELAY. With the default this is `|=> ##2 $rose(ack)`.
- Back-to-back grants:
  - The next grant is made at the same edge where the previous `ack` samples 1.
  - Throughput is one grant per ACK_DELAY edges.
  - `ack` is never high two consecutive cycles for the same grant.
- Worst-case latency for requester i is ACK_DELAY × NUM_REQ edges from its rise.
- Simultaneous rises at one edge are all captured, and the lowest RR-order index is granted first.

## Structure
- Shared package `req_ack_pkg`:
  - state enum `sched_state_t {IDLE, COUNT, ACK}`.
  - `CNT_W` localparam derivation (4 bits covers ACK_DELAY ≤ 15).
- Sub-module `rr_picker`: purely combinational.
  - Inputs: candidate vector, last index.
  - Outputs: `valid`, `index`.
- The top holds the FSM, counter, pending/`req_q` registers and the sticky drop flag.

## Test plan
- Single pulse: `req[0]` rises at edge 10, held 1 cycle, ACK_DELAY=3 → `ack=4'b0001` sampled at edge 13 only; `busy` 1 from edge 10 through edge 13; `grant_id=0`.
- Simultaneous: `req[1]` and `req[2]` rise at edge T from reset → `ack[1]` at T+3, `ack[2]` at T+6, `busy` continuous T..T+6.
- Round robin: all four requesters re-pulse after each ack for 12 grants → grant order 0,1,2,3 repeating; no requester waits more than 12 edges.
- Drop: `req[3]` rises at edge T and again at T+2 while pending behind an active grant → `dropped=1` from T+2; only one `ack[3]`.
- Reset mid-COUNT: `rst_n=0` at edge G+1 after a grant → `ack` stays 0, `busy=0` immediately; `req` held high rises again post-release → ack ACK_DELAY edges later.
- ACK_DELAY=2 with `req[0]` held high for 10 cycles → exactly one `ack[0]` at edge T+2, none afterwards.
